// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring 32-bit divide unit for the execute stage
module ex_div #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    op,
  input  logic [DW-1:0] num1,
  input  logic [DW-1:0] num2,
  input  logic          annul,
  output logic          stallreq,
  output logic          busy,
  output logic          result_valid,
  output logic [DW-1:0] lo_o,
  output logic [DW-1:0] hi_o,
  output logic          div_by_zero
);

  localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP = 8'h1B;
  localparam int         CW          = $clog2(DW);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*DW:0]  work;
  logic [DW-1:0]  divisor;
  logic [CW-1:0]  cnt;
  logic           neg_q;
  logic           neg_r;

  logic           is_div;
  logic           is_signed;
  logic           start;
  logic [DW-1:0]  num1_mag;
  logic [DW-1:0]  num2_mag;
  logic [2*DW:0]  shifted;
  logic [DW+1:0]  trial;
  logic [2*DW:0]  work_step;
  logic [DW-1:0]  quo;
  logic [DW-1:0]  rem;
  logic           unused_top;

  assign is_div    = (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  assign is_signed = (op == EXE_DIV_OP);
  assign start     = is_div && !annul && (state == S_IDLE);

  assign num1_mag = (is_signed && num1[DW-1]) ? -num1 : num1;
  assign num2_mag = (is_signed && num2[DW-1]) ? -num2 : num2;

  // One restoring step: shift, trial-subtract in DW+2 bits so the sign bit is explicit.
  assign shifted   = {work[2*DW-1:0], 1'b0};
  assign trial     = {1'b0, shifted[2*DW:DW]} - {2'b00, divisor};
  assign work_step = trial[DW+1] ? shifted
                                 : {trial[DW:0], shifted[DW-1:1], 1'b1};
  assign quo       = work_step[DW-1:0];
  assign rem       = work_step[2*DW-1:DW];

  // The remainder never exceeds the divisor, so the top work bits carry no information.
  assign unused_top = ^{work[2*DW], work_step[2*DW]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (annul) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = (num2 == '0) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == LAST_CNT) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state == S_BUSY);
    result_valid = (state == S_DONE);
    stallreq     = is_div && !annul && (state != S_DONE);
  end

  // Datapath; a flush leaves the architectural results untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work        <= '0;
      divisor     <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      lo_o        <= '0;
      hi_o        <= '0;
      div_by_zero <= 1'b0;
    end else if (!annul) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num2 == '0) begin
              lo_o        <= '0;
              hi_o        <= '0;
              div_by_zero <= 1'b1;
            end else begin
              neg_q       <= is_signed && (num1[DW-1] ^ num2[DW-1]);
              neg_r       <= is_signed && num1[DW-1];
              divisor     <= num2_mag;
              work        <= {{(DW+1){1'b0}}, num1_mag};
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          work <= work_step;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            lo_o <= neg_q ? -quo : quo;
            hi_o <= neg_r ? -rem : rem;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed self-checking bench for ex_div
module tb_ex_div;

  localparam logic [7:0] DIV  = 8'h1A;
  localparam logic [7:0] DIVU = 8'h1B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  op;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        annul;
  logic        stallreq;
  logic        busy;
  logic        result_valid;
  logic [31:0] lo_o;
  logic [31:0] hi_o;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_div #(.DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .num1         (num1),
    .num2         (num2),
    .annul        (annul),
    .stallreq     (stallreq),
    .busy         (busy),
    .result_valid (result_valid),
    .lo_o         (lo_o),
    .hi_o         (hi_o),
    .div_by_zero  (div_by_zero)
  );

  // Presents one divide in EX and holds it until DONE; returns what was observed.
  task automatic do_div(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int stalls, output bit done,
                        output logic [31:0] lo, output logic [31:0] hi, output logic dbz,
                        output logic stall_done, output bit idle_after);
    int cyc;
    stalls = 0;
    cyc    = 0;
    done   = 0;
    op = o; num1 = a; num2 = b;
    #1;
    while (!done && cyc < 100) begin
      if (result_valid) begin
        done = 1;
      end else begin
        if (stallreq) stalls++;
        if (inject && busy && cyc == 5) begin
          num1 = 32'hFFFF_FFFF;
          num2 = 32'h0;
          op   = (o == DIV) ? DIVU : DIV;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    lo = lo_o; hi = hi_o; dbz = div_by_zero; stall_done = stallreq;
    @(posedge clk); #1;
    op = 8'h00;
    idle_after = !busy && !result_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 8'h00; num1 = 32'd100; num2 = 32'd7; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo_o); end
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi_o); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stallreq); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int stalls; bit done; logic [31:0] lo, hi; logic dbz, sd; bit idle;
    do_div(DIVU, 32'd100, 32'd7, 0, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (!done) begin n_fail++; $display("FAIL divu100_done: got timeout expected result_valid"); end
    n_checks++; if (stalls != 33) begin n_fail++; $display("FAIL divu100_stalls: got %0d expected 33", stalls); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu100_lo: got %0d expected 14", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu100_hi: got %0d expected 2", hi); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL divu100_dbz: got %b expected 0", dbz); end
    n_checks++; if (sd !== 1'b0) begin n_fail++; $display("FAIL divu100_stall_in_done: got %b expected 0", sd); end
    n_checks++; if (!idle) begin n_fail++; $display("FAIL divu100_idle_after: got not idle expected idle"); end
    do_div(DIVU, 32'hFFFF_FFF9, 32'd2, 0, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (lo !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_big_lo: got %h expected 7ffffffc", lo); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL divu_big_hi: got %h expected 1", hi); end
  endtask

  task automatic test_signed();
    int stalls; bit done; logic [31:0] lo, hi; logic dbz, sd; bit idle;
    do_div(DIV, 32'hFFFF_FFF9, 32'd2, 0, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (stalls != 33) begin n_fail++; $display("FAIL div_neg_stalls: got %0d expected 33", stalls); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
  endtask

  task automatic test_div_by_zero();
    int stalls; bit done; logic [31:0] lo, hi; logic dbz, sd; bit idle;
    do_div(DIVU, 32'd5, 32'd0, 0, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (stalls != 1) begin n_fail++; $display("FAIL dbz_stalls: got %0d expected 1", stalls); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL dbz_lo: got %h expected 0", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL dbz_hi: got %h expected 0", hi); end
    n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold: got %b expected 1", div_by_zero); end
  endtask

  task automatic test_overflow();
    int stalls; bit done; logic [31:0] lo, hi; logic dbz, sd; bit idle;
    do_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ovf_hi: got %h expected 0", hi); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz_cleared: got %b expected 0", dbz); end
  endtask

  task automatic test_annul();
    int rv_seen = 0;
    op = DIVU; num1 = 32'd100; num2 = 32'd7;
    #1;
    n_checks++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL annul_stall_c0: got %b expected 1", stallreq); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL annul_busy_c10: got %b expected 1", busy); end
    annul = 1'b1;
    #1;
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_stall_drop: got %b expected 0", stallreq); end
    @(posedge clk); #1;
    annul = 1'b0; op = 8'h00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL annul_idle: got busy=%b expected 0", busy); end
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_stall_after: got %b expected 0", stallreq); end
    for (int i = 0; i < 40; i++) begin
      if (result_valid) rv_seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (rv_seen != 0) begin n_fail++; $display("FAIL annul_no_valid: got %0d pulses expected 0", rv_seen); end
    n_checks++; if (lo_o !== 32'h8000_0000) begin n_fail++; $display("FAIL annul_lo_kept: got %h expected 80000000", lo_o); end
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL annul_hi_kept: got %h expected 0", hi_o); end
  endtask

  task automatic test_mid_reset();
    op = DIVU; num1 = 32'd100; num2 = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mrst_busy_c20: got %b expected 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    op = 8'h00;
    #1;
    n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL mrst_lo: got %h expected 0", lo_o); end
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL mrst_hi: got %h expected 0", hi_o); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b expected 0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b expected 0", result_valid); end
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL mrst_stall: got %b expected 0", stallreq); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int stalls; bit done; logic [31:0] lo, hi; logic dbz, sd; bit idle;
    do_div(DIVU, 32'd9, 32'd3, 1, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (stalls + 1 != 34) begin n_fail++; $display("FAIL b2b1_ex_cycles: got %0d expected 34", stalls + 1); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL b2b1_lo: got %0d expected 3", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL b2b1_hi: got %0d expected 0", hi); end
    do_div(DIVU, 32'd10, 32'd4, 1, stalls, done, lo, hi, dbz, sd, idle);
    n_checks++; if (stalls + 1 != 34) begin n_fail++; $display("FAIL b2b2_ex_cycles: got %0d expected 34", stalls + 1); end
    n_checks++; if (lo !== 32'd2) begin n_fail++; $display("FAIL b2b2_lo: got %0d expected 2", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b2_hi: got %0d expected 2", hi); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL b2b2_dbz: got %b expected 0", dbz); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_annul();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

endmodule
